// File: rtl/keypad_pkg.sv
// Shared keypad types and helpers: FSM state encoding, one-hot decoding
// and the row/column to hex key code map.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} kd_state_t;

  // True when exactly one bit of the 4-bit vector is set
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  // Index of the set bit of a one-hot vector (0 for non one-hot input)
  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    case (v)
      4'b0001: idx = 2'd0;
      4'b0010: idx = 2'd1;
      4'b0100: idx = 2'd2;
      4'b1000: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Physical keypad legend: r0 "123A", r1 "456B", r2 "789C", r3 "E0FD"
  function automatic logic [3:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    code = 4'h0;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_key_decoder_debounce_counter.sv
// Saturating debounce counter with synchronous clear; done flags the
// sample that completes a full debounce window.
module debounce_counter
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 24000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Clear has priority; increment stops at the saturation value
  always_ff @(posedge clk) begin
    if (!nrst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

  // Current sample is the last one of the window when it also matches
  always_comb begin
    done = (count == CNT_LAST);
  end

endmodule

// File: rtl/keypad_key_decoder.sv
// Keypad key decoder: debounces scanner coordinates, emits a one-cycle
// strobe per accepted press and keeps the two most recent key codes.
module keypad_key_decoder
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 24000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic [3:0] col_q,
  input  logic [3:0] row_q,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);

  kd_state_t        state;
  logic [1:0]       lat_r;
  logic [1:0]       lat_c;
  logic             accept_pend;

  logic             cand;
  logic [1:0]       cur_r;
  logic [1:0]       cur_c;
  logic             match;
  logic [3:0]       lat_code;

  logic             cnt_clr;
  logic             cnt_inc;
  logic [CNT_W-1:0] cnt;
  logic             cnt_done;

  debounce_counter #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_cnt (
    .clk  (clk),
    .nrst (nrst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .count(cnt),
    .done (cnt_done)
  );

  // Decode the current sample; chords and empty samples are never a candidate
  always_comb begin
    cand     = is_onehot(col_q) && is_onehot(row_q);
    cur_r    = onehot_to_idx(row_q);
    cur_c    = onehot_to_idx(col_q);
    match    = cand && (cur_r == lat_r) && (cur_c == lat_c);
    lat_code = keymap(lat_r, lat_c);
  end

  // Counter control: count consecutive matching (press) or absent (release) samples
  always_comb begin
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    case (state)
      IDLE: begin
        cnt_inc = cand;
        cnt_clr = !cand;
      end
      DEBOUNCE: begin
        if (match && !cnt_done) cnt_inc = 1'b1;
        else                    cnt_clr = 1'b1;
      end
      HELD: begin
        if (match) cnt_clr = 1'b1;
        else       cnt_inc = 1'b1;
      end
      RELEASE: begin
        if (match || cnt_done) cnt_clr = 1'b1;
        else                   cnt_inc = 1'b1;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Main FSM with coordinate latch, registered outputs and digit shift register.
  // An accept is flagged on entry to HELD and published one edge later.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state       <= IDLE;
      lat_r       <= 2'd0;
      lat_c       <= 2'd0;
      accept_pend <= 1'b0;
      key_code    <= 4'h0;
      key_valid   <= 1'b0;
      key_held    <= 1'b0;
      digit_new   <= 4'h0;
      digit_old   <= 4'h0;
    end else begin
      key_valid   <= 1'b0;
      accept_pend <= 1'b0;
      if (accept_pend) begin
        key_valid <= 1'b1;
        key_code  <= lat_code;
        digit_new <= lat_code;
        digit_old <= digit_new;
      end
      case (state)
        IDLE: begin
          if (cand) begin
            lat_r <= cur_r;
            lat_c <= cur_c;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!match) begin
            state <= IDLE;
          end else if (cnt_done) begin
            state       <= HELD;
            key_held    <= 1'b1;
            accept_pend <= 1'b1;
          end
        end
        HELD: begin
          if (!match) state <= RELEASE;
        end
        RELEASE: begin
          if (match) begin
            state <= HELD;
          end else if (cnt_done) begin
            state    <= IDLE;
            key_held <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          key_valid   <= 1'b0;
          accept_pend <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_key_decoder.sv
// Directed bench for keypad_key_decoder with a 4-cycle debounce window.
module tb_keypad_key_decoder;

  logic       clk;
  logic       nrst;
  logic [3:0] col_q;
  logic [3:0] row_q;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [3:0] digit_new;
  logic [3:0] digit_old;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int dbl    = 0;
  int base   = 0;
  logic prev_valid = 1'b0;

  keypad_key_decoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .nrst     (nrst),
    .col_q    (col_q),
    .row_q    (row_q),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .digit_new(digit_new),
    .digit_old(digit_old)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count strobes and flag any back-to-back pulse
  always @(negedge clk) begin
    if (key_valid && prev_valid) dbl = 1;
    if (key_valid) pulses = pulses + 1;
    prev_valid = key_valid;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_key(input logic [3:0] c, input logic [3:0] r);
    col_q = c;
    row_q = r;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Clean press: strobe on the 5th edge, hold a little, full release
  task automatic do_key(input string tag, input logic [3:0] c, input logic [3:0] r,
                        input logic [3:0] code);
    set_key(c, r);
    tick(4);
    check({tag, "_early_valid"}, {7'd0, key_valid}, 8'd0);
    tick(1);
    check({tag, "_valid"}, {7'd0, key_valid}, 8'd1);
    check({tag, "_code"}, {4'd0, key_code}, {4'd0, code});
    tick(3);
    set_key(4'b0000, 4'b0000);
    tick(3);
    check({tag, "_held_rel3"}, {7'd0, key_held}, 8'd1);
    tick(1);
    check({tag, "_held_rel4"}, {7'd0, key_held}, 8'd0);
  endtask

  initial begin
    // 1. Reset with a key present
    nrst = 1'b0;
    set_key(4'b0001, 4'b0001);
    tick(2);
    check("rst_code", {4'd0, key_code}, 8'd0);
    check("rst_valid", {7'd0, key_valid}, 8'd0);
    check("rst_held", {7'd0, key_held}, 8'd0);
    check("rst_new", {4'd0, digit_new}, 8'd0);
    check("rst_old", {4'd0, digit_old}, 8'd0);
    check("rst_pulses", 8'(pulses), 8'd0);
    nrst = 1'b1;
    set_key(4'b0000, 4'b0000);
    tick(2);

    // 2. Clean press of '6' held 10 cycles
    set_key(4'b0100, 4'b0010);
    tick(4);
    check("p6_valid_e4", {7'd0, key_valid}, 8'd0);
    check("p6_held_e4", {7'd0, key_held}, 8'd1);
    tick(1);
    check("p6_valid_e5", {7'd0, key_valid}, 8'd1);
    check("p6_code", {4'd0, key_code}, 8'h06);
    check("p6_new", {4'd0, digit_new}, 8'h06);
    check("p6_old", {4'd0, digit_old}, 8'h00);
    tick(1);
    check("p6_valid_e6", {7'd0, key_valid}, 8'd0);
    tick(4);
    set_key(4'b0000, 4'b0000);
    tick(3);
    check("p6_held_rel3", {7'd0, key_held}, 8'd1);
    tick(1);
    check("p6_held_rel4", {7'd0, key_held}, 8'd0);
    check("p6_pulses", 8'(pulses), 8'd1);

    // 3. Bounce on '5': short burst then stable press
    set_key(4'b0010, 4'b0010);
    tick(2);
    set_key(4'b0000, 4'b0000);
    tick(1);
    check("b5_burst_pulses", 8'(pulses), 8'd1);
    set_key(4'b0010, 4'b0010);
    tick(4);
    check("b5_valid_e4", {7'd0, key_valid}, 8'd0);
    tick(1);
    check("b5_valid_e5", {7'd0, key_valid}, 8'd1);
    check("b5_code", {4'd0, key_code}, 8'h05);
    check("b5_new", {4'd0, digit_new}, 8'h05);
    check("b5_old", {4'd0, digit_old}, 8'h06);
    tick(2);
    set_key(4'b0000, 4'b0000);
    tick(4);
    check("b5_held_rel", {7'd0, key_held}, 8'd0);
    check("b5_pulses", 8'(pulses), 8'd2);

    // 4. '1' then '0' twice
    do_key("k1", 4'b0001, 4'b0001, 4'h1);
    check("k1_new", {4'd0, digit_new}, 8'h01);
    check("k1_old", {4'd0, digit_old}, 8'h05);
    base = pulses;
    do_key("k0a", 4'b0010, 4'b1000, 4'h0);
    check("k0a_new", {4'd0, digit_new}, 8'h00);
    check("k0a_old", {4'd0, digit_old}, 8'h01);
    do_key("k0b", 4'b0010, 4'b1000, 4'h0);
    check("k0b_new", {4'd0, digit_new}, 8'h00);
    check("k0b_old", {4'd0, digit_old}, 8'h00);
    check("k0_pulses", 8'(pulses - base), 8'd2);

    // 5. Chord never accepted; 'B' ignored while 'A' is held
    base = pulses;
    set_key(4'b0010, 4'b0011);
    tick(8);
    check("chord_held", {7'd0, key_held}, 8'd0);
    check("chord_pulses", 8'(pulses - base), 8'd0);
    set_key(4'b1000, 4'b0001);
    tick(5);
    check("kA_valid", {7'd0, key_valid}, 8'd1);
    check("kA_code", {4'd0, key_code}, 8'h0A);
    set_key(4'b1000, 4'b0011);
    tick(1);
    check("kAB_held1", {7'd0, key_held}, 8'd1);
    tick(3);
    check("kAB_held4", {7'd0, key_held}, 8'd0);
    tick(2);
    check("kAB_pulses", 8'(pulses - base), 8'd1);
    check("kAB_code", {4'd0, key_code}, 8'h0A);
    set_key(4'b0000, 4'b0000);
    tick(2);
    do_key("kB", 4'b1000, 4'b0010, 4'hB);
    check("kB_new", {4'd0, digit_new}, 8'h0B);
    check("kB_old", {4'd0, digit_old}, 8'h0A);

    // 6. Reset mid-debounce on 'F'
    base = pulses;
    set_key(4'b0100, 4'b1000);
    tick(2);
    nrst = 1'b0;
    tick(1);
    check("mid_rst_valid", {7'd0, key_valid}, 8'd0);
    check("mid_rst_held", {7'd0, key_held}, 8'd0);
    check("mid_rst_new", {4'd0, digit_new}, 8'd0);
    check("mid_rst_old", {4'd0, digit_old}, 8'd0);
    nrst = 1'b1;
    set_key(4'b0000, 4'b0000);
    tick(6);
    check("mid_rst_pulses", 8'(pulses - base), 8'd0);
    check("mid_rst_code", {4'd0, key_code}, 8'd0);
    check("mid_rst_new2", {4'd0, digit_new}, 8'd0);

    check("no_double_pulse", 8'(dbl), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
